clock_ctrl: RTL and testbench

Timekeeping controller for the digital-clock datapath. It sequences a BCD cascade HH:MM:SS (mod-10/mod-6 seconds and minutes, mod-24 hours) from a 1 Hz tick derived from clk by an internal prescaler. A three-state mode FSM lets the user set hours and minutes from two button pulses. Outputs feed the display mux directly.

---
 rtl/clock_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clock_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: timekeeping controller for the digital-clock datapath.
//
// A prescaler divides clk down to a once-per-second tick. Each tick advances
// a BCD cascade HH:MM:SS (seconds and minutes wrap at 59, hours wrap at 23).
// A three-state mode FSM lets the user set hours and then minutes with two
// button pulses. Every output is a register and feeds the display mux directly.
//
// Ports:
//   clk       in   system clock; all logic runs on its rising edge
//   rst       in   synchronous, active-high reset; overrides every other input
//   mode_btn  in   single-cycle pulse; steps RUN -> SET_HOUR -> SET_MIN -> RUN
//   inc_btn   in   single-cycle pulse; increments the field being set
//   sec_lo    out  seconds ones digit (BCD 0-9)
//   sec_hi    out  seconds tens digit (BCD 0-5)
//   min_lo    out  minutes ones digit (BCD 0-9)
//   min_hi    out  minutes tens digit (BCD 0-5)
//   hour_lo   out  hours ones digit (BCD 0-9, 0-3 when hour_hi is 2)
//   hour_hi   out  hours tens digit (BCD 0-2)
//   mode      out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   day_co    out  one-cycle pulse after the RUN rollover 23:59:59 -> 00:00:00
//
// Mode FSM states:
//   state    | meaning
//   RUN      | prescaler counts; time advances once every TICK_DIV cycles
//   SET_HOUR | prescaler held at 0; inc_btn advances hours (23 -> 00)
//   SET_MIN  | prescaler held at 0; inc_btn advances minutes (59 -> 00, no carry)

module clock_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hour_lo,
  output logic [3:0] hour_hi,
  output logic [1:0] mode,
  output logic       day_co
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  mode_t         state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;    // {tens, ones}
  logic [7:0]    min_q, min_d;
  logic [7:0]    hour_q, hour_d;
  logic          day_co_q, day_co_d;
  logic          tick;

  // Two-digit BCD increment wrapping 59 -> 00.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-digit BCD increment wrapping 23 -> 00.
  function automatic logic [7:0] inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)            r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      presc_q  <= '0;
      sec_q    <= 8'h00;
      min_q    <= 8'h00;
      hour_q   <= 8'h00;
      day_co_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      day_co_q <= day_co_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    day_co_d = 1'b0;
    tick     = 1'b0;

    case (state_q)
      RUN: begin
        if (presc_q == PS_LAST) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // A mode press on a tick edge still applies that second's increment.
        if (tick) begin
          sec_d = inc60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = inc60(min_q);
            if (min_q == 8'h59) hour_d = inc24(hour_q);
          end
          day_co_d = (sec_q == 8'h59) && (min_q == 8'h59) && (hour_q == 8'h23);
        end
        if (mode_btn) state_d = SET_HOUR;
      end

      SET_HOUR: begin
        presc_d = '0;
        if (mode_btn)     state_d = SET_MIN;
        else if (inc_btn) hour_d  = inc24(hour_q);
      end

      SET_MIN: begin
        presc_d = '0;
        if (mode_btn) begin
          // Restart the second cleanly so the first tick is a full period away.
          state_d = RUN;
          sec_d   = 8'h00;
        end else if (inc_btn) begin
          min_d = inc60(min_q);
        end
      end

      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase
  end

  assign sec_lo  = sec_q[3:0];
  assign sec_hi  = sec_q[7:4];
  assign min_lo  = min_q[3:0];
  assign min_hi  = min_q[7:4];
  assign hour_lo = hour_q[3:0];
  assign hour_hi = hour_q[7:4];
  assign mode    = state_q;
  assign day_co  = day_co_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Testbench for clock_ctrl. The reference model keeps time as seconds-of-day
// and the mode as a small integer; expectations are queued per cycle and a
// monitor on the falling edge pops and compares them against the outputs.

module tb_clock_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, mode_btn, inc_btn;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi;
  logic [1:0] mode;
  logic       day_co;

  always #5 clk = ~clk;

  clock_ctrl #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec_lo   (sec_lo),
    .sec_hi   (sec_hi),
    .min_lo   (min_lo),
    .min_hi   (min_hi),
    .hour_lo  (hour_lo),
    .hour_hi  (hour_hi),
    .mode     (mode),
    .day_co   (day_co)
  );

  typedef struct {
    int          tag;
    logic [23:0] hms;
    logic [1:0]  mode;
    logic        dc;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   dc_seen = 0;

  // Reference model state.
  int   m_t    = 0;   // seconds since midnight
  int   m_mode = 0;   // 0 run, 1 set hour, 2 set minute
  int   m_cnt  = 0;   // cycles into the current second
  logic m_dc   = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic mb, input logic ib);
    int h, m;
    m_dc = 1'b0;
    if (r) begin
      m_t = 0; m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_cnt == TD - 1) begin
            m_cnt = 0;
            if (m_t == 86399) begin m_t = 0; m_dc = 1'b1; end
            else m_t = m_t + 1;
          end else begin
            m_cnt = m_cnt + 1;
          end
          if (mb) begin m_mode = 1; m_cnt = 0; end
        end
        1: begin
          if (mb) m_mode = 2;
          else if (ib) begin
            h = (m_t / 3600 + 1) % 24;
            m_t = h * 3600 + m_t % 3600;
          end
        end
        default: begin
          if (mb) begin
            m_mode = 0;
            m_t = m_t - m_t % 60;
            m_cnt = 0;
          end else if (ib) begin
            m = ((m_t / 60) % 60 + 1) % 60;
            m_t = (m_t / 3600) * 3600 + m * 60 + m_t % 60;
          end
        end
      endcase
    end
  endtask

  // Apply inputs for the next rising edge, queue what that edge must produce.
  task automatic drive(input logic r, input logic mb, input logic ib);
    exp_t e;
    rst      = r;
    mode_btn = mb;
    inc_btn  = ib;
    model_step(r, mb, ib);
    e.tag  = cyc + 1;
    e.hms  = to_bcd(m_t);
    e.mode = 2'(m_mode);
    e.dc   = m_dc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [23:0] dut_hms();
    return {hour_hi, hour_lo, min_hi, min_lo, sec_hi, sec_lo};
  endfunction

  task automatic dchk(input string name, input logic [23:0] hms, input logic [1:0] md);
    #2;
    check({name, "_hms"}, 32'(dut_hms()), 32'(hms));
    check({name, "_mode"}, 32'(mode), 32'(md));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (day_co === 1'b1) dc_seen++;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      check("sb_tag", 32'(e.tag), 32'(cyc));
      check("hms", 32'(dut_hms()), 32'(e.hms));
      check("mode", 32'(mode), 32'(e.mode));
      check("day_co", 32'(day_co), 32'(e.dc));
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    dchk("reset", 24'h000000, 2'd0);
    run(40);
    dchk("run40", 24'h000010, 2'd0);
    check("no_early_day_co", 32'(dc_seen), 32'd0);

    drive(1'b0, 1'b1, 1'b0);
    incs(23);
    dchk("set_h23", 24'h230010, 2'd1);
    drive(1'b0, 1'b1, 1'b0);
    incs(59);
    dchk("set_m59", 24'h235910, 2'd2);
    drive(1'b0, 1'b1, 1'b0);
    dchk("back_run", 24'h235900, 2'd0);
    run(240);
    dchk("rollover", 24'h000000, 2'd0);
    check("rollover_day_co", 32'(day_co), 32'd1);
    run(4);
    dchk("after_roll", 24'h000001, 2'd0);
    check("day_co_count", 32'(dc_seen), 32'd1);

    drive(1'b0, 1'b1, 1'b0);
    incs(24);
    dchk("hour_wrap", 24'h000001, 2'd1);
    check("hour_wrap_dc", 32'(day_co), 32'd0);
    drive(1'b0, 1'b1, 1'b1);
    dchk("mode_and_inc", 24'h000001, 2'd2);
    incs(60);
    dchk("min_wrap", 24'h000001, 2'd2);
    run(100);
    dchk("idle_set_min", 24'h000001, 2'd2);
    drive(1'b0, 1'b1, 1'b0);
    dchk("resume", 24'h000000, 2'd0);
    run(3);
    dchk("resume_3", 24'h000000, 2'd0);
    run(1);
    dchk("resume_4", 24'h000001, 2'd0);

    run(220);
    drive(1'b0, 1'b1, 1'b0);
    incs(12);
    drive(1'b0, 1'b1, 1'b0);
    incs(34);
    dchk("preset", 24'h123456, 2'd2);
    drive(1'b1, 1'b0, 1'b0);
    dchk("mid_set_rst", 24'h000000, 2'd0);
    check("mid_set_rst_dc", 32'(day_co), 32'd0);

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0);

    run(2);
    #10;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
